mfp_ahb_lite_2m_arbiter: RTL



---
 rtl/mfp_ahb_lite_2m_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mfp_ahb_lite_2m_arbiter.sv
// Two-master AHB-Lite arbiter. Address phases from the master that does not own
// the bus are held in a one-entry buffer per master and replayed later, so a
// master is only stalled and never loses a transfer.
module mfp_ahb_lite_2m_arbiter #(
  parameter int unsigned DEFAULT_OWNER = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic        M0_HMASTLOCK,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic        M1_HMASTLOCK,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [2:0]  S_HBURST,
  output logic [3:0]  S_HPROT,
  output logic        S_HMASTLOCK,
  output logic [31:0] S_HWDATA,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HREADY,
  input  logic        S_HRESP
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic [1:0] TRANS_IDLE = 2'b00;
  localparam logic [1:0] DO_NONE    = 2'b00;
  localparam logic [1:0] DO_M0      = 2'b01;
  localparam logic [1:0] DO_M1      = 2'b10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    trans;
    logic          write;
    logic [2:0]    size;
    logic [2:0]    burst;
    logic [3:0]    prot;
    logic          lock;
  } ahb_ctrl_t;

  ahb_ctrl_t live0_c, live1_c, fwd_c;
  ahb_ctrl_t pend0_q, pend0_d, pend1_q, pend1_d;
  logic      pend0_vld_q, pend0_vld_d, pend1_vld_q, pend1_vld_d;
  logic      owner_q, owner_d;
  logic [1:0] downer_q, downer_d;
  logic      hready0_c, hready1_c, acc0_c, acc1_c;
  logic      fwd0_c, fwd1_c, keep_c, other_req_c;
  logic [1:0] own_trans_c;

  // Pack live master address/control and derive per-master ready/accept.
  always_comb begin
    live0_c   = '{addr: M0_HADDR, trans: M0_HTRANS, write: M0_HWRITE, size: M0_HSIZE,
                  burst: M0_HBURST, prot: M0_HPROT, lock: M0_HMASTLOCK};
    live1_c   = '{addr: M1_HADDR, trans: M1_HTRANS, write: M1_HWRITE, size: M1_HSIZE,
                  burst: M1_HBURST, prot: M1_HPROT, lock: M1_HMASTLOCK};
    hready0_c = pend0_vld_q ? 1'b0 : ((downer_q == DO_M0) ? S_HREADY : 1'b1);
    hready1_c = pend1_vld_q ? 1'b0 : ((downer_q == DO_M1) ? S_HREADY : 1'b1);
    acc0_c    = hready0_c & M0_HTRANS[1];
    acc1_c    = hready1_c & M1_HTRANS[1];
  end

  // Owner's buffered transfer wins over its live bus; a stalled live bus is shown as IDLE.
  always_comb begin
    fwd_c = owner_q ? live1_c : live0_c;
    if (!owner_q && pend0_vld_q) begin
      fwd_c = pend0_q;
    end else if (owner_q && pend1_vld_q) begin
      fwd_c = pend1_q;
    end else if ((!owner_q && !hready0_c) || (owner_q && !hready1_c)) begin
      fwd_c.trans = TRANS_IDLE;
    end
    fwd0_c = fwd_c.trans[1] & ~owner_q;
    fwd1_c = fwd_c.trans[1] & owner_q;
  end

  // Next state: buffer capture/clear, data-phase owner and round-robin ownership.
  always_comb begin
    pend0_d     = pend0_q;
    pend1_d     = pend1_q;
    pend0_vld_d = pend0_vld_q;
    pend1_vld_d = pend1_vld_q;
    downer_d    = downer_q;
    owner_d     = owner_q;
    own_trans_c = owner_q ? M1_HTRANS : M0_HTRANS;
    keep_c      = (fwd_c.trans[1] & fwd_c.lock) | own_trans_c[0];
    other_req_c = owner_q ? (pend0_vld_q | acc0_c) : (pend1_vld_q | acc1_c);

    if (pend0_vld_q && !owner_q && S_HREADY) pend0_vld_d = 1'b0;
    if (pend1_vld_q && owner_q && S_HREADY)  pend1_vld_d = 1'b0;
    if (acc0_c && (owner_q || !S_HREADY)) begin
      pend0_vld_d = 1'b1;
      pend0_d     = live0_c;
    end
    if (acc1_c && (!owner_q || !S_HREADY)) begin
      pend1_vld_d = 1'b1;
      pend1_d     = live1_c;
    end

    if (S_HREADY) begin
      downer_d = fwd0_c ? DO_M0 : (fwd1_c ? DO_M1 : DO_NONE);
      if (!keep_c && other_req_c) owner_d = ~owner_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      owner_q     <= 1'(DEFAULT_OWNER);
      downer_q    <= DO_NONE;
      pend0_vld_q <= 1'b0;
      pend1_vld_q <= 1'b0;
      pend0_q     <= '0;
      pend1_q     <= '0;
    end else begin
      owner_q     <= owner_d;
      downer_q    <= downer_d;
      pend0_vld_q <= pend0_vld_d;
      pend1_vld_q <= pend1_vld_d;
      pend0_q     <= pend0_d;
      pend1_q     <= pend1_d;
    end
  end

  assign S_HADDR     = fwd_c.addr;
  assign S_HTRANS    = fwd_c.trans;
  assign S_HWRITE    = fwd_c.write;
  assign S_HSIZE     = fwd_c.size;
  assign S_HBURST    = fwd_c.burst;
  assign S_HPROT     = fwd_c.prot;
  assign S_HMASTLOCK = fwd_c.lock;
  assign S_HWDATA    = (downer_q == DO_M0) ? M0_HWDATA :
                       (downer_q == DO_M1) ? M1_HWDATA : DW'(0);

  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;
  assign M0_HREADY = hready0_c;
  assign M1_HREADY = hready1_c;
  assign M0_HRESP  = (downer_q == DO_M0) ? S_HRESP : 1'b0;
  assign M1_HRESP  = (downer_q == DO_M1) ? S_HRESP : 1'b0;

endmodule
